// File: rtl/fp_add_pkg.sv
// Shared types and constants for the single-precision add issue stage.
package fp_add_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
    localparam logic [7:0]  FP_EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD
    } state_e;

    localparam int FLAG_NAN = 0;
    localparam int FLAG_INF = 1;
    localparam int FLAG_BYP = 2;

endpackage

// File: rtl/fp_operand_fifo.sv
// Operand-pair FIFO: 64-bit entries, power-of-two depth, registered occupancy.
module fp_operand_fifo #(
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [63:0]      wr_data,
    input  logic             pop,
    output logic [63:0]      rd_data,
    output logic [LVL_W-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [63:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fp_add_issue.sv
// Issue/capture stage around a combinational fp32 adder with special-case screening.
// Optional statistics counters are built when FP_ADD_ISSUE_STATS_EN is defined.
module fp_add_issue
    import fp_add_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    output logic [2:0]       out_flags,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    output logic             add_en,
    input  logic [31:0]      add_ans,
    output logic [LVL_W-1:0] fifo_level,
    output logic [15:0]      stat_ops,
    output logic [15:0]      stat_exc
);

    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

    // Returns {flags, sum}; the first matching case wins.
    function automatic logic [34:0] classify(input fp32_t a, input fp32_t b,
                                             input logic [31:0] ans);
        logic       a_nan, b_nan, a_inf, b_inf;
        logic [2:0] flg;
        logic [31:0] res;
        a_nan = (a.exp == FP_EXP_MAX) && (a.man != '0);
        b_nan = (b.exp == FP_EXP_MAX) && (b.man != '0);
        a_inf = (a.exp == FP_EXP_MAX) && (a.man == '0);
        b_inf = (b.exp == FP_EXP_MAX) && (b.man == '0);
        flg   = '0;
        res   = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (a.sign != b.sign))) begin
            flg[FLAG_NAN] = 1'b1;
            flg[FLAG_BYP] = 1'b1;
            res           = FP_QNAN;
        end else if (a_inf || b_inf) begin
            flg[FLAG_INF] = 1'b1;
            flg[FLAG_BYP] = 1'b1;
            res           = {(a_inf ? a.sign : b.sign), FP_EXP_MAX, 23'd0};
        end else if (a.exp == 8'd0 || b.exp == 8'd0) begin
            flg[FLAG_BYP] = 1'b1;
            if (a.exp == 8'd0 && b.exp == 8'd0) res = {a.sign & b.sign, 31'd0};
            else if (a.exp == 8'd0)             res = b;
            else                                res = a;
        end else if (({a.exp, a.man} == {b.exp, b.man}) && (a.sign != b.sign)) begin
            flg[FLAG_BYP] = 1'b1;
            res           = 32'd0;
        end else if (ans[30:23] == FP_EXP_MAX) begin
            flg[FLAG_INF] = 1'b1;
            res           = {ans[31], FP_EXP_MAX, 23'd0};
        end else begin
            res = ans;
        end
        return {flg, res};
    endfunction

    state_e      state, state_nxt;
    logic        push, pop, load;
    logic [31:0] b_eff;
    logic [63:0] head_p0;
    logic [34:0] sel_p0;
    logic [31:0] sum_p1;
    logic [2:0]  flags_p1;
    logic        vld_p1;

    assign in_ready = (fifo_level < DEPTH_L);
    assign push     = in_valid && in_ready;
    assign b_eff    = in_sub ? {~in_b[31], in_b[30:0]} : in_b;

    fp_operand_fifo #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data ({in_a, b_eff}),
        .pop     (pop),
        .rd_data (head_p0),
        .level   (fifo_level)
    );

    assign add_a  = head_p0[63:32];
    assign add_b  = head_p0[31:0];
    assign sel_p0 = classify(fp32_t'(head_p0[63:32]), fp32_t'(head_p0[31:0]), add_ans);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        add_en    = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_level != '0) state_nxt = ISSUE;
            end
            ISSUE: begin
                add_en    = 1'b1;
                pop       = 1'b1;
                load      = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                // A push landing in the same cycle counts as pending work.
                if (vld_p1 && out_ready)
                    state_nxt = ((fifo_level != '0) || push) ? ISSUE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---- result capture stage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            sum_p1   <= '0;
            flags_p1 <= '0;
        end else if (load) begin
            vld_p1   <= 1'b1;
            sum_p1   <= sel_p0[31:0];
            flags_p1 <= sel_p0[34:32];
        end else if (state == HOLD && out_ready) begin
            vld_p1   <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign out_sum   = sum_p1;
    assign out_flags = flags_p1;

`ifdef FP_ADD_ISSUE_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] ops_cnt, exc_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_cnt <= '0;
            exc_cnt <= '0;
        end else if (load) begin
            ops_cnt <= sat_inc(ops_cnt);
            if (sel_p0[32 + FLAG_NAN] || sel_p0[32 + FLAG_INF])
                exc_cnt <= sat_inc(exc_cnt);
        end
    end

    assign stat_ops = ops_cnt;
    assign stat_exc = exc_cnt;
`else
    assign stat_ops = '0;
    assign stat_exc = '0;
`endif

endmodule

// File: tb/tb_fp_add_issue.sv
// Directed self-checking bench for fp_add_issue with a table-driven adder stand-in.
module tb_fp_add_issue;

    logic        clk, rst_n;
    logic        in_valid, in_ready, in_sub;
    logic [31:0] in_a, in_b;
    logic        out_valid, out_ready;
    logic [31:0] out_sum;
    logic [2:0]  out_flags;
    logic [31:0] add_a, add_b, add_ans;
    logic        add_en;
    logic [2:0]  fifo_level;
    logic [15:0] stat_ops, stat_exc;

    int vec  = 0;
    int miss = 0;

    fp_add_issue #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_sub     (in_sub),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_flags  (out_flags),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_en     (add_en),
        .add_ans    (add_ans),
        .fifo_level (fifo_level),
        .stat_ops   (stat_ops),
        .stat_exc   (stat_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed sums for the operand pairs used below; anything else is junk.
    always_comb begin
        add_ans = 32'hDEADBEEF;
        case ({add_a, add_b})
            64'h3F800000_40000000: add_ans = 32'h40400000;
            64'h3F800000_3F800000: add_ans = 32'h40000000;
            64'h40000000_BF800000: add_ans = 32'h3F800000;
            64'h40000000_40000000: add_ans = 32'h40800000;
            64'h40800000_40800000: add_ans = 32'h41000000;
            64'h7F7FFFFF_7F7FFFFF: add_ans = 32'h7F800000;
            default:               add_ans = 32'hDEADBEEF;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] es, input logic [2:0] ef);
        int          n;
        logic [31:0] seen_b, beff;
        beff   = s ? {~b[31], b[30:0]} : b;
        seen_b = 32'd0;
        chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
        in_a = a; in_b = b; in_sub = s; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            if (add_en) seen_b = add_b;
            step();
            n++;
        end
        chk({tag, ".lat"}, 32'(n), 32'd2);
        chk({tag, ".addb"}, seen_b, beff);
        chk({tag, ".sum"}, out_sum, es);
        chk({tag, ".flg"}, 32'(out_flags), 32'(ef));
        step();
        chk({tag, ".vclr"}, 32'(out_valid), 32'd0);
    endtask

    logic [31:0] bpa [6] = '{32'h3F800000, 32'h3F800000, 32'h40000000,
                             32'h7F800000, 32'h40000000, 32'h40800000};
    logic [31:0] bpb [6] = '{32'h40000000, 32'h3F800000, 32'h3F800000,
                             32'h3F800000, 32'h40000000, 32'h40800000};
    logic        bps [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] bpe [6] = '{32'h40400000, 32'h40000000, 32'h3F800000,
                             32'h7F800000, 32'h40800000, 32'h41000000};
    logic [2:0]  bpf [6] = '{3'b000, 3'b000, 3'b000, 3'b110, 3'b000, 3'b000};

    initial begin
        int   k, cyc;
        logic acc, hs, saw_valid;

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
        #12;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_sum", out_sum, 32'd0);
        chk("rst.out_flags", 32'(out_flags), 32'd0);
        chk("rst.add_en", 32'(add_en), 32'd0);
        chk("rst.level", 32'(fifo_level), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        #5 rst_n = 1'b1;
        step();

        run_op("add12",   32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000);
        run_op("sub33",   32'h40400000, 32'h40400000, 1'b1, 32'h00000000, 3'b100);
        run_op("nan_a",   32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b101);
        run_op("inf_opp", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b101);
        run_op("inf_sub", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b101);
        run_op("inf_neg", 32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000, 3'b110);
        run_op("ovf",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b010);
        run_op("zero_a",  32'h00000000, 32'h3F800000, 1'b0, 32'h3F800000, 3'b100);
        run_op("negzero", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b100);
        run_op("denorm",  32'h00000001, 32'h40000000, 1'b0, 32'h40000000, 3'b100);

        // Backpressure: output stalled, five pairs fill FIFO plus output register.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp.push_rdy", 32'(in_ready), 32'd1);
            in_a = bpa[i]; in_b = bpb[i]; in_sub = bps[i]; in_valid = 1'b1;
            step();
        end
        chk("bp.level_full", 32'(fifo_level), 32'd4);
        chk("bp.rdy_low", 32'(in_ready), 32'd0);
        chk("bp.first_sum", out_sum, bpe[0]);
        in_a = bpa[5]; in_b = bpb[5]; in_sub = bps[5]; in_valid = 1'b1;
        step(); step(); step();
        chk("bp.held_level", 32'(fifo_level), 32'd4);
        chk("bp.held_rdy", 32'(in_ready), 32'd0);
        chk("bp.stall_vld", 32'(out_valid), 32'd1);
        chk("bp.stall_sum", out_sum, bpe[0]);
        chk("bp.stall_flg", 32'(out_flags), 32'(bpf[0]));

        out_ready = 1'b1;
        k = 0; cyc = 0;
        while (k < 6 && cyc < 80) begin
            acc = in_valid && in_ready;
            hs  = out_valid;
            if (hs) begin
                chk("bp.sum", out_sum, bpe[k]);
                chk("bp.flg", 32'(out_flags), 32'(bpf[k]));
                k++;
            end
            step();
            cyc++;
            if (acc) in_valid = 1'b0;
        end
        chk("bp.count", 32'(k), 32'd6);
        chk("bp.in_dropped", 32'(in_valid), 32'd0);
        step(); step();
        chk("bp.drain_vld", 32'(out_valid), 32'd0);
        chk("bp.drain_lvl", 32'(fifo_level), 32'd0);

        // Reset while holding a result with another pair still queued.
        out_ready = 1'b0;
        in_a = 32'h3F800000; in_b = 32'h40000000; in_sub = 1'b0; in_valid = 1'b1;
        step();
        in_a = 32'h40000000; in_b = 32'h40000000;
        step();
        in_valid = 1'b0;
        step();
        chk("rh.pre_vld", 32'(out_valid), 32'd1);
        chk("rh.pre_lvl", 32'(fifo_level), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("rh.out_valid", 32'(out_valid), 32'd0);
        chk("rh.level", 32'(fifo_level), 32'd0);
        chk("rh.in_ready", 32'(in_ready), 32'd1);
        chk("rh.out_sum", out_sum, 32'd0);
        chk("rh.add_en", 32'(add_en), 32'd0);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid || add_en) saw_valid = 1'b1;
        end
        chk("rh.no_stale", 32'(saw_valid), 32'd0);

        run_op("post_rst", 32'h40800000, 32'h40800000, 1'b0, 32'h41000000, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
